request_unit: RTL

Front-end sequencer sitting directly upstream of the control unit. Fetches each instruction from instruction memory, holds it stable in an instruction register that drives the control unit's `imemload`, then uses the control unit's decoded `dREN`/`dWEN`/`halt`/`RegWr` to run the data-memory phase. Issues the single-cycle PC-advance and register-file write strobes when an instruction retires. Keeps saturating retire and stall counters for bring-up.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/request_unit_if.sv | 37 +++
 rtl/sat_counter.sv | 33 +++
 rtl/request_unit.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word and the request sequencer state encoding.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    FETCH,
    EXEC,
    MEM,
    HALTED
  } reqstate_t;

endpackage

// File: rtl/request_unit_if.sv
// Signal bundle between the request unit and its environment.
interface request_unit_if #(
  parameter int unsigned CNT_W = 32
);
  import cpu_types_pkg::*;

  logic             ihit;
  word_t            iload;
  logic             dhit;
  logic             cu_dREN;
  logic             cu_dWEN;
  logic             cu_halt;
  logic             cu_RegWr;
  word_t            instr;
  logic             imemREN;
  logic             dmemREN;
  logic             dmemWEN;
  logic             pc_en;
  logic             rf_wen;
  logic             halt;
  logic             err;
  logic [CNT_W-1:0] instr_count;
  logic [CNT_W-1:0] stall_count;

  modport ru (
    input  ihit, iload, dhit, cu_dREN, cu_dWEN, cu_halt, cu_RegWr,
    output instr, imemREN, dmemREN, dmemWEN, pc_en, rf_wen, halt, err,
    output instr_count, stall_count
  );

  modport tb (
    output ihit, iload, dhit, cu_dREN, cu_dWEN, cu_halt, cu_RegWr,
    input  instr, imemREN, dmemREN, dmemWEN, pc_en, rf_wen, halt, err,
    input  instr_count, stall_count
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Advance on inc unless already saturated
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/request_unit.sv
// Fetch / decode-wait / data-memory sequencer in front of the control unit.
module request_unit
  import cpu_types_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  word_t            iload,
  input  logic             dhit,
  input  logic             cu_dREN,
  input  logic             cu_dWEN,
  input  logic             cu_halt,
  input  logic             cu_RegWr,
  output word_t            instr,
  output logic             imemREN,
  output logic             dmemREN,
  output logic             dmemWEN,
  output logic             pc_en,
  output logic             rf_wen,
  output logic             halt,
  output logic             err,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] stall_count
);

  reqstate_t state_q;
  reqstate_t state_d;
  word_t     instr_q;
  word_t     instr_d;
  logic      err_q;
  logic      err_d;
  logic      stall_inc;

  // State register plus the held instruction and sticky error flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= FETCH;
      instr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      instr_q <= instr_d;
      err_q   <= err_d;
    end
  end

  // Next-state selection; instr only loads on an accepted fetch
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    err_d   = err_q;
    case (state_q)
      FETCH: begin
        if (ihit) begin
          instr_d = iload;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cu_halt) begin
          state_d = HALTED;
        end else if (cu_dREN || cu_dWEN) begin
          state_d = MEM;
        end else begin
          state_d = FETCH;
        end
      end
      MEM: begin
        if (cu_dREN && cu_dWEN) begin
          err_d = 1'b1;
        end
        if (dhit) begin
          state_d = FETCH;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  // Requests and strobes; retire strobes follow the decode/dhit of this cycle
  always_comb begin
    imemREN   = 1'b0;
    dmemREN   = 1'b0;
    dmemWEN   = 1'b0;
    pc_en     = 1'b0;
    rf_wen    = 1'b0;
    halt      = 1'b0;
    stall_inc = 1'b0;
    case (state_q)
      FETCH: begin
        imemREN   = 1'b1;
        stall_inc = ~ihit;
      end
      EXEC: begin
        if (!cu_halt && !cu_dREN && !cu_dWEN) begin
          pc_en  = 1'b1;
          rf_wen = cu_RegWr;
        end
      end
      MEM: begin
        dmemREN = cu_dREN;
        dmemWEN = cu_dWEN & ~cu_dREN;
        if (dhit) begin
          pc_en  = 1'b1;
          rf_wen = cu_RegWr;
        end else begin
          stall_inc = 1'b1;
        end
      end
      HALTED: begin
        halt = 1'b1;
      end
      default: begin
        halt = 1'b0;
      end
    endcase
  end

  assign instr = instr_q;
  assign err   = err_q;

  sat_counter #(.W(CNT_W)) u_instr_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (pc_en),
    .count(instr_count)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .CLK  (CLK),
    .RST  (RST),
    .inc  (stall_inc),
    .count(stall_count)
  );

endmodule
